acc_cpu_core: RTL and testbench

Parametrised multicycle accumulator processor core: single-bus datapath with PC/MAR/MDR/IR/AC, on-chip program/data RAM, 8-instruction ISA. Replaces the divided-clock board top: the core runs on the system clock, throttled by a `step_en` clock-enable. It talks to a display or host through a valid/ready output port and a program-load port usable only while halted.

---
 rtl/acc_cpu_pkg.sv | 39 +++
 rtl/acc_cpu_ram.sv | 33 +++
 rtl/acc_cpu_core.sv | 199 +++++++++++++++++++
 tb/tb_acc_cpu_core.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_cpu_pkg.sv
// Shared types and instruction-field helpers for the accumulator CPU core.
package acc_cpu_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_JMP   = 3'd4,
    OP_JZ    = 3'd5,
    OP_OUT   = 3'd6,
    OP_HALT  = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    ST_HALTED   = 3'd0,
    ST_FETCH    = 3'd1,
    ST_IFETCH   = 3'd2,
    ST_DECODE   = 3'd3,
    ST_OPREAD   = 3'd4,
    ST_EXEC     = 3'd5,
    ST_OUT_WAIT = 3'd6
  } state_e;

  // Opcode sits in the top three bits of a data_w-wide word.
  function automatic opcode_e instr_opcode(input logic [MAX_W-1:0] word, input int data_w);
    logic [MAX_W-1:0] sh;
    sh = word >> (data_w - 3);
    return opcode_e'(sh[2:0]);
  endfunction

  function automatic logic [MAX_W-1:0] instr_operand(input logic [MAX_W-1:0] word,
                                                     input int addr_w);
    return word & ((64'd1 << addr_w) - 64'd1);
  endfunction

endpackage

// File: rtl/acc_cpu_ram.sv
// Single-port synchronous RAM, one-cycle read latency; out-of-range accesses
// read as zero and drop writes so partial depths never alias.
module acc_cpu_ram #(
  parameter int DATA_W    = 18,
  parameter int ADDR_W    = 13,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  assign in_range = 32'(addr_i) < MEM_DEPTH;
  assign idx      = IDX_W'(addr_i);
  assign rdata_o  = rdata_q;

  always_ff @(posedge clk) begin
    if (we_i && in_range) begin
      mem_q[idx] <= wdata_i;
    end
    rdata_q <= in_range ? mem_q[idx] : '0;
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Multicycle accumulator CPU: PC/MAR/MDR/IR/AC datapath around a synchronous RAM,
// gated by step_en, with a valid/ready output port and a halted-only load port.
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W    = 18,
  parameter int ADDR_W    = 13,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_en,
  input  logic              run,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_dbg,
  output logic [DATA_W-1:0] ac_dbg,
  output logic              zero,
  output logic              neg,
  output logic              ovf
);

  localparam int MSB = DATA_W - 1;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] mdr_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] ac_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              ovf_q;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  opcode_e           dec_op;
  opcode_e           exe_op;
  logic [ADDR_W-1:0] dec_operand;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              add_ovf;
  logic              sub_ovf;
  logic              ac_zero;

  always_comb begin
    dec_op      = instr_opcode(MAX_W'(mdr_q), DATA_W);
    exe_op      = instr_opcode(MAX_W'(ir_q), DATA_W);
    dec_operand = ADDR_W'(instr_operand(MAX_W'(mdr_q), ADDR_W));
    sum         = ac_q + mdr_q;
    diff        = ac_q - mdr_q;
    add_ovf     = (ac_q[MSB] == mdr_q[MSB]) && (sum[MSB] != ac_q[MSB]);
    sub_ovf     = (ac_q[MSB] != mdr_q[MSB]) && (diff[MSB] != ac_q[MSB]);
    ac_zero     = (ac_q == '0);
  end

  // The RAM address is steered one state early so read data lands in MDR in
  // the state that follows: PC during FETCH, the operand during DECODE.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = mar_q;
    ram_wdata = ac_q;
    case (state_q)
      ST_HALTED: begin
        ram_we    = prog_we;
        ram_addr  = prog_addr;
        ram_wdata = prog_wdata;
      end
      ST_FETCH:  ram_addr = pc_q;
      ST_DECODE: begin
        ram_addr = dec_operand;
        ram_we   = step_en && (dec_op == OP_STORE);
      end
      default: ;
    endcase
  end

  acc_cpu_ram #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HALTED;
      pc_q        <= '0;
      mar_q       <= '0;
      mdr_q       <= '0;
      ir_q        <= '0;
      ac_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_HALTED: begin
          if (run) state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          if (step_en) begin
            mar_q   <= pc_q;
            state_q <= ST_IFETCH;
          end
        end
        ST_IFETCH: begin
          if (step_en) begin
            mdr_q   <= ram_rdata;
            pc_q    <= pc_q + 1'b1;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (step_en) begin
            ir_q  <= mdr_q;
            mar_q <= dec_operand;
            case (dec_op)
              OP_JMP: begin
                pc_q    <= dec_operand;
                state_q <= ST_FETCH;
              end
              OP_JZ: begin
                if (ac_zero) pc_q <= dec_operand;
                state_q <= ST_FETCH;
              end
              OP_STORE: state_q <= ST_FETCH;
              OP_HALT:  state_q <= ST_HALTED;
              default:  state_q <= ST_OPREAD;
            endcase
          end
        end
        ST_OPREAD: begin
          if (step_en) begin
            mdr_q   <= ram_rdata;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (step_en) begin
            state_q <= ST_FETCH;
            case (exe_op)
              OP_LOAD: begin
                ac_q  <= mdr_q;
                ovf_q <= 1'b0;
              end
              OP_ADD: begin
                ac_q  <= sum;
                ovf_q <= ovf_q | add_ovf;
              end
              OP_SUB: begin
                ac_q  <= diff;
                ovf_q <= ovf_q | sub_ovf;
              end
              OP_OUT: begin
                out_data_q  <= mdr_q;
                out_valid_q <= 1'b1;
                state_q     <= ST_OUT_WAIT;
              end
              default: ;
            endcase
          end
        end
        ST_OUT_WAIT: begin
          // Handshake: a word moves on any edge where out_valid and out_ready are
          // both high; out_data holds steady until then and step_en is ignored.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_FETCH;
          end
        end
        default: state_q <= ST_HALTED;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign halted    = (state_q == ST_HALTED);
  assign pc_dbg    = pc_q;
  assign ac_dbg    = ac_q;
  assign zero      = ac_zero;
  assign neg       = ac_q[MSB];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core: stimulus pushes expected OUT words into a
// queue that an output monitor drains; state checks follow each program run.
module tb_acc_cpu_core;

  localparam int DW = 18;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          step_en = 1'b1;
  logic          run;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_wdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          halted;
  logic [AW-1:0] pc_dbg;
  logic [DW-1:0] ac_dbg;
  logic          zero, neg, ovf;

  logic          s_run, s_we;
  logic [3:0]    s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_out_valid;
  logic [DW-1:0] s_out_data;
  logic          s_halted;
  logic [3:0]    s_pc;
  logic [DW-1:0] s_ac;
  logic          s_zero, s_neg, s_ovf;

  int            n_vec = 0;
  int            n_err = 0;
  int            xfers = 0;
  int            cyc = 0;
  int            pc_t[16];
  bit            throttle = 1'b0;
  logic [DW-1:0] exp_q[$];

  acc_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(1024)) u_dut (
    .clk(clk), .reset(reset), .step_en(step_en), .run(run),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .halted(halted), .pc_dbg(pc_dbg), .ac_dbg(ac_dbg),
    .zero(zero), .neg(neg), .ovf(ovf)
  );

  acc_cpu_core #(.DATA_W(DW), .ADDR_W(4), .MEM_DEPTH(16)) u_small (
    .clk(clk), .reset(reset), .step_en(1'b1), .run(s_run),
    .prog_we(s_we), .prog_addr(s_addr), .prog_wdata(s_wdata),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data),
    .halted(s_halted), .pc_dbg(s_pc), .ac_dbg(s_ac),
    .zero(s_zero), .neg(s_neg), .ovf(s_ovf)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : throttle_drv
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      step_en = throttle ? (ph % 4 == 0) : 1'b1;
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [DW-1:0] ins(input logic [2:0] op, input int operand);
    return {op, 15'(operand)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_halted"},    64'(halted),    64'd1);
    check({tag, "_pc"},        64'(pc_dbg),    64'd0);
    check({tag, "_ac"},        64'(ac_dbg),    64'd0);
    check({tag, "_zero"},      64'(zero),      64'd1);
    check({tag, "_neg"},       64'(neg),       64'd0);
    check({tag, "_ovf"},       64'(ovf),       64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_data"},  64'(out_data),  64'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic load(input bit sm, input int addr, input logic [DW-1:0] data);
    @(posedge clk);
    #1;
    if (sm) begin
      s_we = 1'b1; s_addr = 4'(addr); s_wdata = data;
    end else begin
      prog_we = 1'b1; prog_addr = AW'(addr); prog_wdata = data;
    end
    @(posedge clk);
    #1;
    prog_we = 1'b0;
    s_we    = 1'b0;
  endtask

  task automatic run_pulse(input bit sm);
    @(posedge clk);
    #1;
    if (sm) s_run = 1'b1; else run = 1'b1;
    @(posedge clk);
    #1;
    s_run = 1'b0;
    run   = 1'b0;
  endtask

  task automatic wait_halt(input bit sm, input int budget, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sm ? s_halted : halted) && n < budget);
    check(name, 64'(sm ? s_halted : halted), 64'd1);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(out_valid), 64'd1);
  endtask

  task automatic load_demo();
    load(0, 0, ins(0, 10));
    load(0, 1, ins(2, 11));
    load(0, 2, ins(6, 12));
    load(0, 3, ins(1, 12));
    load(0, 4, ins(6, 12));
    load(0, 5, ins(7, 0));
    load(0, 10, 18'd5);
    load(0, 11, 18'd7);
    load(0, 12, 18'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial forever begin
    @(negedge clk);
    if (out_valid && out_ready) begin
      xfers++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL out_unexpected: got %0h expected no transfer", out_data);
      end else begin
        check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin : pc_timer
    logic [AW-1:0] last_pc;
    last_pc = '0;
    forever begin
      @(negedge clk);
      if (pc_dbg !== last_pc) begin
        last_pc = pc_dbg;
        if (pc_dbg < 16) pc_t[pc_dbg[3:0]] = cyc;
      end
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    reset = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    out_ready = 1'b1; s_run = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset("rst0");
    check("small_halted", 64'(s_halted), 64'd1);

    // demo program at full rate
    load_demo();
    exp_q.push_back(18'd0);
    exp_q.push_back(18'd12);
    xfers = 0;
    run_pulse(0);
    wait_halt(0, 300, "demo_halt");
    check("demo_pc", 64'(pc_dbg), 64'd6);
    check("demo_ac", 64'(ac_dbg), 64'd12);
    check("demo_flags", {61'd0, zero, neg, ovf}, 64'd0);
    check("demo_xfers", 64'(xfers), 64'd2);
    check("demo_q_empty", 64'(exp_q.size()), 64'd0);
    check("demo_load_cycles", 64'(pc_t[2] - pc_t[1]), 64'd5);
    check("demo_store_cycles", 64'(pc_t[5] - pc_t[4]), 64'd3);

    // consumer stalls 20 cycles on the first OUT
    do_reset();
    load_demo();
    out_ready = 1'b0;
    exp_q.push_back(18'd0);
    exp_q.push_back(18'd12);
    xfers = 0;
    run_pulse(0);
    wait_valid(100, "stall_valid");
    repeat (20) begin
      @(negedge clk);
      check("stall_hold", {13'd0, out_valid, out_data[17:0], pc_dbg, ac_dbg},
            {13'd0, 1'b1, 18'd0, 13'd3, 18'd12});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_halt(0, 300, "stall_halt");
    check("stall_xfers", 64'(xfers), 64'd2);
    check("stall_ac", 64'(ac_dbg), 64'd12);
    check("stall_pc", 64'(pc_dbg), 64'd6);

    // step_en one cycle in four
    do_reset();
    load_demo();
    exp_q.push_back(18'd0);
    exp_q.push_back(18'd12);
    xfers = 0;
    throttle = 1'b1;
    run_pulse(0);
    wait_halt(0, 800, "thr_halt");
    throttle = 1'b0;
    check("thr_pc", 64'(pc_dbg), 64'd6);
    check("thr_ac", 64'(ac_dbg), 64'd12);
    check("thr_xfers", 64'(xfers), 64'd2);
    check("thr_load_cycles", 64'(pc_t[2] - pc_t[1]), 64'd20);
    check("thr_store_cycles", 64'(pc_t[5] - pc_t[4]), 64'd12);

    // signed overflow, LOAD clearing ovf, SUB wrap
    do_reset();
    load(0, 0, ins(0, 10));
    load(0, 1, ins(2, 11));
    load(0, 2, ins(7, 0));
    load(0, 10, 18'h1FFFF);
    load(0, 11, 18'd1);
    run_pulse(0);
    wait_halt(0, 100, "ovf_halt");
    check("ovf_ac", 64'(ac_dbg), 64'h20000);
    check("ovf_flags", {61'd0, zero, neg, ovf}, 64'b011);
    load(0, 3, ins(0, 11));
    load(0, 4, ins(7, 0));
    run_pulse(0);
    wait_halt(0, 100, "ovf_clr_halt");
    check("ovf_clr_ac", 64'(ac_dbg), 64'd1);
    check("ovf_clr_flags", {61'd0, zero, neg, ovf}, 64'b000);
    load(0, 5, ins(0, 12));
    load(0, 6, ins(3, 11));
    load(0, 7, ins(7, 0));
    load(0, 12, 18'd0);
    run_pulse(0);
    wait_halt(0, 100, "sub_halt");
    check("sub_ac", 64'(ac_dbg), 64'h3FFFF);
    check("sub_flags", {61'd0, zero, neg, ovf}, 64'b010);
    check("sub_pc", 64'(pc_dbg), 64'd8);

    // JZ taken and not taken
    do_reset();
    load(0, 0, ins(0, 20));
    load(0, 1, ins(4, 3));
    load(0, 2, ins(7, 0));
    load(0, 3, ins(5, 7));
    load(0, 4, ins(7, 0));
    load(0, 7, ins(7, 0));
    load(0, 20, 18'd0);
    run_pulse(0);
    wait_halt(0, 100, "jz_t_halt");
    check("jz_taken_pc", 64'(pc_dbg), 64'd8);
    do_reset();
    load(0, 20, 18'd3);
    run_pulse(0);
    wait_halt(0, 100, "jz_n_halt");
    check("jz_not_pc", 64'(pc_dbg), 64'd5);
    check("jz_not_ac", 64'(ac_dbg), 64'd3);

    // addresses beyond MEM_DEPTH read zero and drop writes
    do_reset();
    load(0, 0, ins(0, 10));
    load(0, 1, ins(1, 1036));
    load(0, 2, ins(0, 1036));
    load(0, 3, ins(6, 12));
    load(0, 4, ins(7, 0));
    load(0, 10, 18'd5);
    load(0, 12, 18'h21);
    exp_q.push_back(18'h21);
    run_pulse(0);
    wait_halt(0, 100, "oor_halt");
    check("oor_ac", 64'(ac_dbg), 64'd0);
    check("oor_zero", 64'(zero), 64'd1);
    check("oor_q_empty", 64'(exp_q.size()), 64'd0);

    // self loop; load port ignored while running
    do_reset();
    load(0, 0, ins(4, 0));
    load(0, 30, 18'h55);
    run_pulse(0);
    @(posedge clk);
    #1;
    prog_we = 1'b1; prog_addr = AW'(30); prog_wdata = 18'h1234;
    repeat (50) @(posedge clk);
    #1 prog_we = 1'b0;
    @(negedge clk);
    check("loop_running", 64'(halted), 64'd0);
    check("loop_pc_range", 64'(pc_dbg <= 1), 64'd1);
    do_reset();
    @(negedge clk);
    check_reset("rst_loop");
    load(0, 0, ins(6, 30));
    load(0, 1, ins(7, 0));
    exp_q.push_back(18'h55);
    run_pulse(0);
    wait_halt(0, 100, "guard_halt");
    check("guard_q_empty", 64'(exp_q.size()), 64'd0);

    // reset while in OUT_WAIT
    do_reset();
    load(0, 0, ins(6, 10));
    load(0, 1, ins(7, 0));
    load(0, 10, 18'h15);
    out_ready = 1'b0;
    run_pulse(0);
    wait_valid(100, "ow_valid");
    check("ow_data", 64'(out_data), 64'h15);
    do_reset();
    @(negedge clk);
    check_reset("rst_ow");
    out_ready = 1'b1;

    // reset while in EXEC of an ADD
    load(0, 0, ins(2, 11));
    load(0, 11, 18'd7);
    run_pulse(0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset("rst_exec");

    // PC wrap on the 4-bit-address instance
    load(1, 0, ins(7, 0));
    load(1, 1, ins(4, 15));
    load(1, 15, ins(0, 5));
    load(1, 5, 18'd9);
    run_pulse(1);
    wait_halt(1, 100, "wrap_h0");
    check("wrap_pc0", 64'(s_pc), 64'd1);
    run_pulse(1);
    wait_halt(1, 100, "wrap_h1");
    check("wrap_pc", 64'(s_pc), 64'd1);
    check("wrap_ac", 64'(s_ac), 64'd9);
    check("wrap_flags", {60'd0, s_out_valid, s_zero, s_neg, s_ovf}, 64'd0);
    check("wrap_out_data", 64'(s_out_data), 64'd0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
